// File: rtl/dcache_snoop_ctrl_pkg.sv
// Shared configuration and types for the D-cache snoop controller.
package taiga_config;
    localparam int DCACHE_LINES     = 512;
    localparam int DCACHE_OFFSET_W  = 4;
    localparam int SNOOP_MAX_WAIT   = 4;
    localparam int SNOOP_FIFO_DEPTH = 2;
    localparam int DCACHE_IDX_W     = $clog2(DCACHE_LINES);
    localparam int DCACHE_TAG_W     = 32 - DCACHE_IDX_W - DCACHE_OFFSET_W;
endpackage

package taiga_types;
    import taiga_config::*;

    // One tag-store entry: valid bit above the stored tag.
    typedef struct packed {
        logic                    valid;
        logic [DCACHE_TAG_W-1:0] tag;
    } dtag_entry_t;

    // A queued snoop request from the peer core.
    typedef struct packed {
        logic [31:0] addr;
        logic        inv;
    } snoop_req_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOOKUP,
        S_COMPARE,
        S_INV_WAIT
    } snoop_state_t;
endpackage

// File: rtl/dcache_snoop_ctrl_fifo.sv
// Small in-order snoop request queue: valid/ready push, pop/empty drain.
module snoop_req_fifo
    import taiga_types::*;
#(
    parameter int DEPTH = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push_valid,
    output logic       push_ready,
    input  snoop_req_t push_data,
    input  logic       pop,
    output snoop_req_t pop_data,
    output logic       empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    snoop_req_t       r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    // A full queue refuses new requests; there is no pass-through path.
    assign push_ready = (r_count != FULL_COUNT);
    assign empty      = (r_count == '0);
    assign w_push     = push_valid && push_ready;
    assign w_pop      = pop && !empty;
    assign pop_data   = r_mem[r_rd_ptr];

    // Entry storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: rtl/dcache_snoop_ctrl.sv
// Snoop sequencer: queues peer-core snoops, looks each up on the dedicated
// tag read port and, on a hit-invalidate, borrows the shared write port A
// from the local D-cache (forcing it after a bounded wait).
module dcache_snoop_ctrl
    import taiga_config::*;
    import taiga_types::*;
#(
    parameter  int LINES      = DCACHE_LINES,
    parameter  int OFFSET_W   = DCACHE_OFFSET_W,
    parameter  int FIFO_DEPTH = SNOOP_FIFO_DEPTH,
    parameter  int MAX_WAIT   = SNOOP_MAX_WAIT,
    localparam int IDX_W      = $clog2(LINES),
    localparam int TAG_W      = 32 - IDX_W - OFFSET_W,
    localparam int ENTRY_W    = TAG_W + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               snoop_valid,
    output logic               snoop_ready,
    input  logic [31:0]        snoop_addr,
    input  logic               snoop_inv,
    output logic               resp_valid,
    output logic               resp_hit,
    input  logic               loc_en_a,
    input  logic               loc_wen_a,
    input  logic [IDX_W-1:0]   loc_addr_a,
    input  logic [ENTRY_W-1:0] loc_data_a,
    output logic               loc_stall,
    output logic               tag_en_a,
    output logic               tag_wen_a,
    output logic [IDX_W-1:0]   tag_addr_a1,
    output logic [ENTRY_W-1:0] tag_data_in_a,
    output logic [IDX_W-1:0]   tag_addr_a2,
    input  logic [ENTRY_W-1:0] tag_data_out_a2
);
    localparam int CNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(MAX_WAIT);

    snoop_state_t     r_state, w_state_next;
    logic [IDX_W-1:0] r_idx, w_idx_next;
    logic [TAG_W-1:0] r_tag, w_tag_next;
    logic             r_inv, w_inv_next;
    logic [CNT_W-1:0] r_wait, w_wait_next;
    logic             r_resp_valid, w_resp_valid_next;
    logic             r_resp_hit, w_resp_hit_next;

    snoop_req_t       w_push_req;
    snoop_req_t       w_head;
    logic             w_pop;
    logic             w_fifo_empty;
    logic             w_loc_wr;
    logic             w_same_idx;
    logic             w_hit;
    logic             w_own;
    logic             w_unused_offset;

    assign w_push_req = '{addr: snoop_addr, inv: snoop_inv};

    snoop_req_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_req_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_valid (snoop_valid),
        .push_ready (snoop_ready),
        .push_data  (w_push_req),
        .pop        (w_pop),
        .pop_data   (w_head),
        .empty      (w_fifo_empty)
    );

    // Byte-offset bits never reach the tag store.
    assign w_unused_offset = ^w_head.addr[OFFSET_W-1:0];

    assign tag_addr_a2 = r_idx;
    assign resp_valid  = r_resp_valid;
    assign resp_hit    = r_resp_hit;

    assign w_loc_wr   = loc_en_a && loc_wen_a;
    assign w_same_idx = w_loc_wr && (loc_addr_a == r_idx);
    assign w_hit      = tag_data_out_a2[ENTRY_W-1] && (tag_data_out_a2[TAG_W-1:0] == r_tag);
    // Port A is free when local is idle; after MAX_WAIT blocked cycles it is taken.
    assign w_own      = !loc_en_a || (r_wait == WAIT_LIMIT);

    // Next-state, working-register updates and port-A arbitration.
    always_comb begin
        w_state_next      = r_state;
        w_idx_next        = r_idx;
        w_tag_next        = r_tag;
        w_inv_next        = r_inv;
        w_wait_next       = r_wait;
        w_resp_valid_next = 1'b0;
        w_resp_hit_next   = 1'b0;
        w_pop             = 1'b0;
        tag_en_a          = loc_en_a;
        tag_wen_a         = loc_wen_a;
        tag_addr_a1       = loc_addr_a;
        tag_data_in_a     = loc_data_a;
        loc_stall         = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (!w_fifo_empty) begin
                    w_pop        = 1'b1;
                    w_idx_next   = w_head.addr[OFFSET_W+IDX_W-1:OFFSET_W];
                    w_tag_next   = w_head.addr[31:OFFSET_W+IDX_W];
                    w_inv_next   = w_head.inv;
                    w_state_next = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                // A local write steals the snoop bank's port and voids this read.
                if (!w_loc_wr) begin
                    w_state_next = S_COMPARE;
                end
            end
            S_COMPARE: begin
                if (w_same_idx) begin
                    w_state_next = S_LOOKUP;
                end else if (w_hit && r_inv) begin
                    w_state_next = S_INV_WAIT;
                end else begin
                    w_resp_valid_next = 1'b1;
                    w_resp_hit_next   = w_hit;
                    w_state_next      = S_IDLE;
                end
            end
            S_INV_WAIT: begin
                if (w_own) begin
                    tag_en_a          = 1'b1;
                    tag_wen_a         = 1'b1;
                    tag_addr_a1       = r_idx;
                    tag_data_in_a     = {1'b0, r_tag};
                    loc_stall         = loc_en_a;
                    w_resp_valid_next = 1'b1;
                    w_resp_hit_next   = 1'b1;
                    w_wait_next       = '0;
                    w_state_next      = S_IDLE;
                end else if (w_same_idx) begin
                    // The line may have been refilled, so look it up again.
                    w_wait_next  = '0;
                    w_state_next = S_LOOKUP;
                end else if (r_wait != WAIT_LIMIT) begin
                    w_wait_next = r_wait + CNT_W'(1);
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // State, working request, wait counter and registered response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_idx        <= '0;
            r_tag        <= '0;
            r_inv        <= 1'b0;
            r_wait       <= '0;
            r_resp_valid <= 1'b0;
            r_resp_hit   <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_idx        <= w_idx_next;
            r_tag        <= w_tag_next;
            r_inv        <= w_inv_next;
            r_wait       <= w_wait_next;
            r_resp_valid <= w_resp_valid_next;
            r_resp_hit   <= w_resp_hit_next;
        end
    end
endmodule

// File: tb/tb_dcache_snoop_ctrl.sv
// Directed bench for dcache_snoop_ctrl with a behavioural dual-port tag store.
module tb_dcache_snoop_ctrl;
    localparam int LINES   = 512;
    localparam int IDX_W   = 9;
    localparam int ENTRY_W = 20;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               snoop_valid;
    logic               snoop_ready;
    logic [31:0]        snoop_addr;
    logic               snoop_inv;
    logic               resp_valid;
    logic               resp_hit;
    logic               loc_en_a;
    logic               loc_wen_a;
    logic [IDX_W-1:0]   loc_addr_a;
    logic [ENTRY_W-1:0] loc_data_a;
    logic               loc_stall;
    logic               tag_en_a;
    logic               tag_wen_a;
    logic [IDX_W-1:0]   tag_addr_a1;
    logic [ENTRY_W-1:0] tag_data_in_a;
    logic [IDX_W-1:0]   tag_addr_a2;
    logic [ENTRY_W-1:0] tag_data_out_a2;

    int checks = 0;
    int errors = 0;
    int dut_writes = 0;
    int w0;
    int n_resp;
    logic exp_hits [3];
    logic [ENTRY_W-1:0] tag_mem [LINES];

    dcache_snoop_ctrl dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .snoop_valid     (snoop_valid),
        .snoop_ready     (snoop_ready),
        .snoop_addr      (snoop_addr),
        .snoop_inv       (snoop_inv),
        .resp_valid      (resp_valid),
        .resp_hit        (resp_hit),
        .loc_en_a        (loc_en_a),
        .loc_wen_a       (loc_wen_a),
        .loc_addr_a      (loc_addr_a),
        .loc_data_a      (loc_data_a),
        .loc_stall       (loc_stall),
        .tag_en_a        (tag_en_a),
        .tag_wen_a       (tag_wen_a),
        .tag_addr_a1     (tag_addr_a1),
        .tag_data_in_a   (tag_data_in_a),
        .tag_addr_a2     (tag_addr_a2),
        .tag_data_out_a2 (tag_data_out_a2)
    );

    always #5 clk = ~clk;

    // Tag store: port A write, port a2 registered read.
    always @(posedge clk) begin
        if (tag_en_a && tag_wen_a) tag_mem[tag_addr_a1] <= tag_data_in_a;
        tag_data_out_a2 <= tag_mem[tag_addr_a2];
    end

    // Count writes issued by the controller itself (local idle or stalled).
    always @(posedge clk) begin
        if (tag_en_a && tag_wen_a && (!loc_en_a || loc_stall)) dut_writes <= dut_writes + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic loc_write(input logic [IDX_W-1:0] idx, input logic [ENTRY_W-1:0] data);
        loc_en_a   = 1'b1;
        loc_wen_a  = 1'b1;
        loc_addr_a = idx;
        loc_data_a = data;
        step();
        loc_en_a   = 1'b0;
        loc_wen_a  = 1'b0;
    endtask

    task automatic send(input logic [31:0] addr, input logic inv);
        snoop_valid = 1'b1;
        snoop_addr  = addr;
        snoop_inv   = inv;
        check("send_ready", snoop_ready, 1);
        step();
        snoop_valid = 1'b0;
    endtask

    // edges counts clock edges from the accepting edge up to the response.
    task automatic expect_resp(input string tag, input int edges, input logic hit);
        for (int i = 1; i <= edges - 2; i++) begin
            step();
            check({tag, "_early"}, resp_valid, 0);
        end
        step();
        check({tag, "_valid"}, resp_valid, 1);
        check({tag, "_hit"}, resp_hit, hit);
        step();
        check({tag, "_pulse"}, resp_valid, 0);
    endtask

    initial begin
        rst_n       = 1'b0;
        snoop_valid = 1'b0;
        snoop_addr  = '0;
        snoop_inv   = 1'b0;
        loc_en_a    = 1'b0;
        loc_wen_a   = 1'b0;
        loc_addr_a  = '0;
        loc_data_a  = '0;
        exp_hits    = '{1'b1, 1'b0, 1'b1};

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_resp_hit", resp_hit, 0);
        check("rst_loc_stall", loc_stall, 0);
        rst_n = 1'b1;
        step();
        check("rst_snoop_ready", snoop_ready, 1);

        // 1: hit-invalidate with port A free, response 5 edges after accept
        loc_write(9'h123, 20'hC0000);
        w0 = dut_writes;
        send(32'h8000_1230, 1'b1);
        step();
        step();
        check("s1_early", resp_valid, 0);
        step();
        check("s1_tag_en", tag_en_a, 1);
        check("s1_tag_wen", tag_wen_a, 1);
        check("s1_tag_addr", tag_addr_a1, 32'h123);
        check("s1_tag_data", tag_data_in_a, 32'h40000);
        check("s1_no_stall", loc_stall, 0);
        check("s1_not_yet", resp_valid, 0);
        step();
        check("s1_resp_valid", resp_valid, 1);
        check("s1_resp_hit", resp_hit, 1);
        check("s1_mem", tag_mem[9'h123], 32'h40000);
        check("s1_writes", dut_writes, w0 + 1);
        step();
        check("s1_pulse", resp_valid, 0);

        // 2: probe miss, 4 edges, no write
        loc_write(9'h123, 20'hC0000);
        w0 = dut_writes;
        send(32'h0000_1230, 1'b0);
        expect_resp("s2", 4, 1'b0);
        check("s2_no_write", dut_writes, w0);
        check("s2_mem", tag_mem[9'h123], 32'hC0000);

        // 3: starvation, forced grant after 4 blocked INV_WAIT cycles
        loc_write(9'h123, 20'hC0000);
        loc_en_a   = 1'b1;
        loc_wen_a  = 1'b0;
        loc_addr_a = 9'h050;
        loc_data_a = 20'h00555;
        send(32'h8000_1230, 1'b1);
        step();
        step();
        step();
        loc_wen_a = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("s3_blocked_stall", loc_stall, 0);
            check("s3_blocked_addr", tag_addr_a1, 32'h050);
            step();
        end
        check("s3_forced_stall", loc_stall, 1);
        check("s3_forced_addr", tag_addr_a1, 32'h123);
        check("s3_forced_data", tag_data_in_a, 32'h40000);
        check("s3_forced_wen", tag_wen_a, 1);
        step();
        check("s3_resp_valid", resp_valid, 1);
        check("s3_resp_hit", resp_hit, 1);
        check("s3_stall_released", loc_stall, 0);
        check("s3_passthru", tag_addr_a1, 32'h050);
        loc_en_a  = 1'b0;
        loc_wen_a = 1'b0;
        check("s3_mem_inv", tag_mem[9'h123], 32'h40000);
        check("s3_mem_local", tag_mem[9'h050], 32'h00555);

        // 4: same-index local write during COMPARE forces a re-lookup
        loc_write(9'h123, 20'hC0000);
        w0 = dut_writes;
        send(32'h8000_1230, 1'b1);
        step();
        step();
        loc_en_a   = 1'b1;
        loc_wen_a  = 1'b1;
        loc_addr_a = 9'h123;
        loc_data_a = 20'h80001;
        step();
        loc_en_a  = 1'b0;
        loc_wen_a = 1'b0;
        check("s4_no_resp_a", resp_valid, 0);
        step();
        check("s4_no_resp_b", resp_valid, 0);
        step();
        check("s4_resp_valid", resp_valid, 1);
        check("s4_resp_hit", resp_hit, 0);
        check("s4_no_write", dut_writes, w0);
        check("s4_mem", tag_mem[9'h123], 32'h80001);

        // 5: three back-to-back snoops fill the queue, answered in order
        snoop_valid = 1'b1;
        snoop_inv   = 1'b0;
        snoop_addr  = 32'h0000_3230;
        check("s5_ready_a", snoop_ready, 1);
        step();
        snoop_addr = 32'h8000_1230;
        check("s5_ready_b", snoop_ready, 1);
        step();
        snoop_addr = 32'h0000_3230;
        check("s5_ready_c", snoop_ready, 1);
        step();
        snoop_valid = 1'b0;
        check("s5_full", snoop_ready, 0);
        n_resp = 0;
        for (int i = 0; i < 12; i++) begin
            if (resp_valid) begin
                if (n_resp < 3) check("s5_order", resp_hit, exp_hits[n_resp]);
                n_resp++;
            end
            step();
        end
        check("s5_count", n_resp, 3);
        check("s5_ready_end", snoop_ready, 1);

        // 6: reset while the controller owns port A in INV_WAIT
        loc_write(9'h123, 20'hC0000);
        w0 = dut_writes;
        loc_en_a   = 1'b1;
        loc_wen_a  = 1'b0;
        loc_addr_a = 9'h050;
        send(32'h8000_1230, 1'b1);
        step();
        step();
        step();
        check("s6_blocked_addr", tag_addr_a1, 32'h050);
        loc_en_a = 1'b0;
        #1;
        check("s6_owned", tag_en_a, 1);
        rst_n = 1'b0;
        #1;
        check("s6_rst_tag_en", tag_en_a, 0);
        check("s6_rst_tag_wen", tag_wen_a, 0);
        check("s6_rst_resp", resp_valid, 0);
        check("s6_rst_stall", loc_stall, 0);
        @(negedge clk);
        check("s6_no_write", dut_writes, w0);
        check("s6_mem", tag_mem[9'h123], 32'hC0000);
        rst_n = 1'b1;
        check("s6_ready", snoop_ready, 1);
        step();
        check("s6_dropped_a", resp_valid, 0);
        step();
        check("s6_dropped_b", resp_valid, 0);
        send(32'h8000_1230, 1'b0);
        expect_resp("s6_after", 4, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
